// File: rtl/imm_build_seq_if.sv
// Signal bundle between instruction decode, the zero extender and the operand mux.
// Optional SIGNED input is present only when IMM_BUILD_SEQ_SIGN_EXT_EN is defined.
interface imm_build_seq_if #(
    parameter int DATA_W = 16,
    parameter int NIB_W  = 4
);
    // Handshakes: a nibble moves on a cycle where nib_valid && nib_ready; the
    // immediate is taken on a cycle where imm_valid && imm_ack. Neither side's
    // valid may depend on the other side's ready/ack.
    logic              start;
    logic [1:0]        nib_cnt;
    logic [NIB_W-1:0]  nib_in;
    logic              nib_valid;
    logic              nib_ready;
    logic [NIB_W-1:0]  zx_a;
    logic [DATA_W-1:0] zx_r;
    logic [DATA_W-1:0] imm_out;
    logic              imm_valid;
    logic              imm_ack;
    logic              busy;
    logic [1:0]        state_dbg;
`ifdef IMM_BUILD_SEQ_SIGN_EXT_EN
    logic              is_signed;

    modport master (
        output start, nib_cnt, nib_in, nib_valid, zx_r, imm_ack, is_signed,
        input  nib_ready, zx_a, imm_out, imm_valid, busy, state_dbg
    );
    modport slave (
        input  start, nib_cnt, nib_in, nib_valid, zx_r, imm_ack, is_signed,
        output nib_ready, zx_a, imm_out, imm_valid, busy, state_dbg
    );
`else
    modport master (
        output start, nib_cnt, nib_in, nib_valid, zx_r, imm_ack,
        input  nib_ready, zx_a, imm_out, imm_valid, busy, state_dbg
    );
    modport slave (
        input  start, nib_cnt, nib_in, nib_valid, zx_r, imm_ack,
        output nib_ready, zx_a, imm_out, imm_valid, busy, state_dbg
    );
`endif
endinterface

// File: rtl/imm_build_seq.sv
// Builds a right-justified immediate from 1-4 nibbles through the shared zero extender.
// Define IMM_BUILD_SEQ_SIGN_EXT_EN to add sign extension of short immediates.
module imm_build_seq #(
    parameter int DATA_W = 16,
    parameter int NIB_W  = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    imm_build_seq_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] last_val;
    logic              nib_ready;
    logic              imm_valid;

    assign shifted = (acc_q << NIB_W) | bus.zx_r;

`ifdef IMM_BUILD_SEQ_SIGN_EXT_EN
    logic [1:0]        len_q, len_d;
    logic              sgn_q, sgn_d;
    logic [DATA_W-1:0] hi_mask;
    logic [DATA_W-1:0] top_mask;

    // hi_mask covers bits above the built immediate; top_mask is its sign bit.
    // A full-width build shifts hi_mask to zero, leaving the value untouched.
    assign hi_mask  = {DATA_W{1'b1}} << (NIB_W * (32'(len_q) + 32'd1));
    assign top_mask = (hi_mask >> 1) & ~hi_mask;
    assign last_val = (sgn_q && |(shifted & top_mask)) ? (shifted | hi_mask) : shifted;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q <= 2'd0;
            sgn_q <= 1'b0;
        end else begin
            len_q <= len_d;
            sgn_q <= sgn_d;
        end
    end
`else
    assign last_val = shifted;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        nib_ready = 1'b0;
        imm_valid = 1'b0;
`ifdef IMM_BUILD_SEQ_SIGN_EXT_EN
        len_d     = len_q;
        sgn_d     = sgn_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    cnt_d   = bus.nib_cnt;
                    acc_d   = '0;
                    state_d = COLLECT;
`ifdef IMM_BUILD_SEQ_SIGN_EXT_EN
                    len_d   = bus.nib_cnt;
                    sgn_d   = bus.is_signed;
`endif
                end
            end
            COLLECT: begin
                nib_ready = 1'b1;
                if (bus.nib_valid) begin
                    if (cnt_q == 2'd0) begin
                        acc_d   = last_val;
                        state_d = DONE;
                    end else begin
                        acc_d = shifted;
                        cnt_d = cnt_q - 2'd1;
                    end
                end
            end
            DONE: begin
                imm_valid = 1'b1;
                if (bus.imm_ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // acc doubles as the output register so the result survives the ack.
    assign bus.zx_a      = bus.nib_in;
    assign bus.imm_out   = acc_q;
    assign bus.imm_valid = imm_valid;
    assign bus.nib_ready = nib_ready;
    assign bus.busy      = (state_q != IDLE);
    assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_imm_build_seq.sv
// Bench for imm_build_seq: directed vector table, reset corner case and random builds
// against an arithmetic reference model. Honours IMM_BUILD_SEQ_SIGN_EXT_EN.
module tb_imm_build_seq;
    localparam int DATA_W = 16;
    localparam int NIB_W  = 4;
`ifdef IMM_BUILD_SEQ_SIGN_EXT_EN
    localparam bit SEXT = 1'b1;
`else
    localparam bit SEXT = 1'b0;
`endif

    typedef struct {
        logic [1:0]        cnt;
        logic [DATA_W-1:0] nibs;
        int                gap;
        int                ack_delay;
        bit                sgn;
        bit                poke;
        logic [DATA_W-1:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [DATA_W-1:0] exp_q[$];
    vec_t vecs[$];

    // clock / reset
    always #5 clk = ~clk;

    imm_build_seq_if #(.DATA_W(DATA_W), .NIB_W(NIB_W)) bus ();

    imm_build_seq #(.DATA_W(DATA_W), .NIB_W(NIB_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // the shared 4b->16b zero extender
    assign bus.zx_r = DATA_W'(bus.zx_a);

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference: concatenate nibbles arithmetically, optionally reinterpret as signed
    function automatic logic [DATA_W-1:0] model(input int n, input logic [3:0] nb[4], input bit sgn);
        longint v = 0;
        for (int i = 0; i < n; i++) v = v * 16 + longint'(nb[i]);
        if (SEXT && sgn && v >= (longint'(1) << (4 * n - 1))) v -= (longint'(1) << (4 * n));
        return DATA_W'(v);
    endfunction

    task automatic idle_inputs();
        bus.start     = 1'b0;
        bus.nib_cnt   = 2'd0;
        bus.nib_in    = '0;
        bus.nib_valid = 1'b0;
        bus.imm_ack   = 1'b0;
`ifdef IMM_BUILD_SEQ_SIGN_EXT_EN
        bus.is_signed = 1'b0;
`endif
    endtask

    // driver: one full build; expected value already queued by caller
    task automatic run_build(input logic [1:0] cnt, input logic [3:0] nibs[4], input int gap,
                             input int ack_delay, input bit sgn, input bit poke);
        int cycles;
        logic [DATA_W-1:0] exp_v;
        @(negedge clk);
        check("idle_busy", 32'(bus.busy), 32'd0);
        bus.start   = 1'b1;
        bus.nib_cnt = cnt;
`ifdef IMM_BUILD_SEQ_SIGN_EXT_EN
        bus.is_signed = sgn;
`else
        if (sgn) $display("note: signed build requested without sign extension");
`endif
        @(negedge clk);
        cycles = 1;
        bus.start   = poke;
        bus.nib_cnt = 2'($urandom);
        check("start_to_ready", 32'(bus.nib_ready), 32'd1);
        check("collect_busy", 32'(bus.busy), 32'd1);
        for (int k = 0; k <= int'(cnt); k++) begin
            for (int g = 0; g < gap; g++) begin
                bus.nib_valid = 1'b0;
                bus.nib_in    = 4'($urandom);
                @(negedge clk);
                cycles++;
                check("gap_ready", 32'(bus.nib_ready), 32'd1);
            end
            bus.nib_valid = 1'b1;
            bus.nib_in    = nibs[k];
            #1;
            check("zx_pass", 32'(bus.zx_a), 32'(nibs[k]));
            @(negedge clk);
            cycles++;
        end
        bus.nib_valid = 1'b0;
        bus.start     = poke;
        exp_v = exp_q.pop_front();
        check("done_valid", 32'(bus.imm_valid), 32'd1);
        check("done_ready", 32'(bus.nib_ready), 32'd0);
        check("imm_out", 32'(bus.imm_out), 32'(exp_v));
        for (int d = 0; d < ack_delay; d++) begin
            bus.nib_valid = 1'b1;
            bus.nib_in    = 4'hE;
            @(negedge clk);
            cycles++;
            check("hold_valid", 32'(bus.imm_valid), 32'd1);
            check("hold_out", 32'(bus.imm_out), 32'(exp_v));
            check("hold_ready", 32'(bus.nib_ready), 32'd0);
        end
        bus.nib_valid = 1'b0;
        bus.imm_ack   = 1'b1;
        bus.start     = poke;
        @(negedge clk);
        cycles++;
        bus.imm_ack = 1'b0;
        bus.start   = 1'b0;
        check("ack_valid", 32'(bus.imm_valid), 32'd0);
        check("ack_busy", 32'(bus.busy), 32'd0);
        check("ack_hold", 32'(bus.imm_out), 32'(exp_v));
        if (gap == 0 && ack_delay == 0) check("build_len", 32'(cycles), 32'(int'(cnt) + 3));
    endtask

    task automatic add_vec(input logic [1:0] cnt, input logic [DATA_W-1:0] nibs, input int gap,
                           input int ack_delay, input bit sgn, input bit poke, input logic [DATA_W-1:0] exp);
        vec_t v;
        v.cnt = cnt; v.nibs = nibs; v.gap = gap; v.ack_delay = ack_delay;
        v.sgn = sgn; v.poke = poke; v.exp = exp;
        vecs.push_back(v);
    endtask

    initial begin
        logic [3:0] nb[4];
        logic [1:0] rc;
        bit         rs;

        add_vec(2'd3, 16'hABCD, 0, 0, 1'b0, 1'b0, 16'hABCD);
        add_vec(2'd3, 16'hABCD, 0, 2, 1'b0, 1'b0, 16'hABCD);
        add_vec(2'd1, 16'h007F, 3, 0, 1'b0, 1'b0, 16'h007F);
        add_vec(2'd2, 16'h0123, 0, 1, 1'b0, 1'b1, 16'h0123);
        add_vec(2'd0, 16'h0009, 0, 5, 1'b0, 1'b0, 16'h0009);
        add_vec(2'd2, 16'h0FFF, 1, 0, 1'b0, 1'b1, 16'h0FFF);
        add_vec(2'd1, 16'h0081, 0, 0, 1'b0, 1'b0, 16'h0081);
`ifdef IMM_BUILD_SEQ_SIGN_EXT_EN
        add_vec(2'd1, 16'h0081, 0, 0, 1'b1, 1'b0, 16'hFF81);
        add_vec(2'd3, 16'h8001, 0, 0, 1'b1, 1'b0, 16'h8001);
        add_vec(2'd0, 16'h0008, 0, 1, 1'b1, 1'b0, 16'hFFF8);
        add_vec(2'd2, 16'h0712, 0, 0, 1'b1, 1'b0, 16'h0712);
`endif

        idle_inputs();
        repeat (3) @(negedge clk);
        check("rst_imm_out", 32'(bus.imm_out), 32'd0);
        check("rst_imm_valid", 32'(bus.imm_valid), 32'd0);
        check("rst_nib_ready", 32'(bus.nib_ready), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        rst_n = 1'b1;

        // reset after two of four nibbles
        @(negedge clk);
        bus.start   = 1'b1;
        bus.nib_cnt = 2'd3;
        @(negedge clk);
        bus.start     = 1'b0;
        bus.nib_valid = 1'b1;
        bus.nib_in    = 4'hA;
        @(negedge clk);
        bus.nib_in = 4'hB;
        @(negedge clk);
        bus.nib_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_imm_out", 32'(bus.imm_out), 32'd0);
        check("midrst_imm_valid", 32'(bus.imm_valid), 32'd0);
        check("midrst_nib_ready", 32'(bus.nib_ready), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        nb = '{4'h5, 4'h0, 4'h0, 4'h0};
        exp_q.push_back(16'h0005);
        run_build(2'd0, nb, 0, 0, 1'b0, 1'b0);

        // directed table
        foreach (vecs[i]) begin
            for (int k = 0; k < 4; k++) begin
                if (k <= int'(vecs[i].cnt))
                    nb[k] = 4'(vecs[i].nibs >> (4 * (int'(vecs[i].cnt) - k)));
                else
                    nb[k] = 4'h0;
            end
            exp_q.push_back(vecs[i].exp);
            run_build(vecs[i].cnt, nb, vecs[i].gap, vecs[i].ack_delay, vecs[i].sgn, vecs[i].poke);
        end

        // random builds against the model
        for (int r = 0; r < 30; r++) begin
            rc = 2'($urandom_range(0, 3));
            for (int k = 0; k < 4; k++) nb[k] = 4'($urandom);
            rs = SEXT ? 1'($urandom_range(0, 1)) : 1'b0;
            exp_q.push_back(model(int'(rc) + 1, nb, rs));
            run_build(rc, nb, $urandom_range(0, 2), $urandom_range(0, 3), rs, 1'($urandom_range(0, 1)));
        end

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
